// File: rtl/l1_mem_arbiter.sv
// Round-robin arbiter between the L1 icache and dcache, serializing one line
// transaction at a time onto the shared L2 port. All outputs are registered.
module l1_mem_arbiter (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_pmem_read,
  input  logic [15:0]  i_pmem_address,
  output logic [127:0] i_pmem_rdata,
  output logic         i_pmem_resp,
  input  logic         d_pmem_read,
  input  logic         d_pmem_write,
  input  logic [15:0]  d_pmem_address,
  input  logic [127:0] d_pmem_wdata,
  output logic [127:0] d_pmem_rdata,
  output logic         d_pmem_resp,
  output logic         l2_read,
  output logic         l2_write,
  output logic [15:0]  l2_address,
  output logic [127:0] l2_wdata,
  input  logic [127:0] l2_rdata,
  input  logic         l2_resp
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t         state_r, state_nxt_s;
  logic           owner_d_r, owner_d_nxt_s;
  logic           op_write_r, op_write_nxt_s;
  logic           last_grant_d_r, last_grant_d_nxt_s;
  logic [15:0]    addr_r, addr_nxt_s;
  logic [127:0]   wdata_r, wdata_nxt_s;
  logic [127:0]   line_r, line_nxt_s;
  logic           l2_read_r, l2_read_nxt_s;
  logic           l2_write_r, l2_write_nxt_s;
  logic           i_resp_r, i_resp_nxt_s;
  logic           d_resp_r, d_resp_nxt_s;
  logic           i_req_s, d_req_s, grant_d_s, grant_wr_s;

  // Request decode and round-robin tie break (1 = dcache wins)
  always_comb begin
    i_req_s   = i_pmem_read;
    d_req_s   = d_pmem_read | d_pmem_write;
    grant_d_s = 1'b0;
    if (i_req_s && d_req_s) begin
      grant_d_s = ~last_grant_d_r;
    end else begin
      grant_d_s = d_req_s;
    end
    grant_wr_s = grant_d_s & d_pmem_write;
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_req_s || d_req_s) begin
          state_nxt_s = ST_SERVE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_SERVE: begin
        if (l2_resp) begin
          state_nxt_s = ST_RESP;
        end else begin
          state_nxt_s = ST_SERVE;
        end
      end
      ST_RESP: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Next values of the latches and of every registered output
  always_comb begin
    owner_d_nxt_s      = owner_d_r;
    op_write_nxt_s     = op_write_r;
    last_grant_d_nxt_s = last_grant_d_r;
    addr_nxt_s         = addr_r;
    wdata_nxt_s        = wdata_r;
    line_nxt_s         = line_r;
    l2_read_nxt_s      = 1'b0;
    l2_write_nxt_s     = 1'b0;
    i_resp_nxt_s       = 1'b0;
    d_resp_nxt_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (i_req_s || d_req_s) begin
          owner_d_nxt_s      = grant_d_s;
          op_write_nxt_s     = grant_wr_s;
          last_grant_d_nxt_s = grant_d_s;
          addr_nxt_s         = grant_d_s ? d_pmem_address : i_pmem_address;
          l2_read_nxt_s      = ~grant_wr_s;
          l2_write_nxt_s     = grant_wr_s;
          if (grant_wr_s) begin
            wdata_nxt_s = d_pmem_wdata;
          end else begin
            wdata_nxt_s = wdata_r;
          end
        end else begin
          owner_d_nxt_s = owner_d_r;
        end
      end
      ST_SERVE: begin
        if (l2_resp) begin
          // Writebacks leave the line register untouched
          line_nxt_s   = op_write_r ? line_r : l2_rdata;
          i_resp_nxt_s = ~owner_d_r;
          d_resp_nxt_s = owner_d_r;
        end else begin
          l2_read_nxt_s  = ~op_write_r;
          l2_write_nxt_s = op_write_r;
        end
      end
      ST_RESP: begin
        l2_read_nxt_s  = 1'b0;
        l2_write_nxt_s = 1'b0;
      end
      default: begin
        l2_read_nxt_s  = 1'b0;
        l2_write_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      owner_d_r      <= 1'b0;
      op_write_r     <= 1'b0;
      last_grant_d_r <= 1'b1;
      addr_r         <= 16'h0000;
      wdata_r        <= 128'd0;
      line_r         <= 128'd0;
      l2_read_r      <= 1'b0;
      l2_write_r     <= 1'b0;
      i_resp_r       <= 1'b0;
      d_resp_r       <= 1'b0;
    end else begin
      owner_d_r      <= owner_d_nxt_s;
      op_write_r     <= op_write_nxt_s;
      last_grant_d_r <= last_grant_d_nxt_s;
      addr_r         <= addr_nxt_s;
      wdata_r        <= wdata_nxt_s;
      line_r         <= line_nxt_s;
      l2_read_r      <= l2_read_nxt_s;
      l2_write_r     <= l2_write_nxt_s;
      i_resp_r       <= i_resp_nxt_s;
      d_resp_r       <= d_resp_nxt_s;
    end
  end

  assign i_pmem_rdata = line_r;
  assign d_pmem_rdata = line_r;
  assign i_pmem_resp  = i_resp_r;
  assign d_pmem_resp  = d_resp_r;
  assign l2_read      = l2_read_r;
  assign l2_write     = l2_write_r;
  assign l2_address   = addr_r;
  assign l2_wdata     = wdata_r;

endmodule

// File: tb/tb_l1_mem_arbiter.sv
// Randomized self-checking bench for l1_mem_arbiter; the bench plays both L1
// requesters and the L2 port and predicts grants from a round-robin model.
module tb_l1_mem_arbiter;

  logic         clk;
  logic         reset_n;
  logic         i_pmem_read;
  logic [15:0]  i_pmem_address;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [15:0]  d_pmem_address;
  logic [127:0] d_pmem_wdata;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         l2_read;
  logic         l2_write;
  logic [15:0]  l2_address;
  logic [127:0] l2_wdata;
  logic [127:0] l2_rdata;
  logic         l2_resp;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: who won last (1 = dcache) and the line last filled
  bit           model_last_d;
  logic [127:0] exp_line;

  l1_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_address(l2_address),
    .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called in an IDLE cycle with requests already driven; ends in the resp cycle.
  task automatic run_txn(input int delay, input logic [127:0] rline, input bit scramble,
                         output bit owner);
    bit           i_req, d_req, is_wr;
    logic [15:0]  addr;
    logic [127:0] wd;
    i_req = i_pmem_read;
    d_req = d_pmem_read | d_pmem_write;
    if (i_req && d_req) owner = ~model_last_d;
    else                owner = d_req;
    is_wr = owner & d_pmem_write;
    addr  = owner ? d_pmem_address : i_pmem_address;
    wd    = d_pmem_wdata;
    model_last_d = owner;
    step();
    for (int c = 0; c <= delay; c++) begin
      n_cmp++;
      if ({l2_read, l2_write} !== {~is_wr, is_wr}) begin
        n_err++;
        $display("FAIL l2_req cyc%0d: got %b required %b", c + 1, {l2_read, l2_write}, {~is_wr, is_wr});
      end
      n_cmp++;
      if (l2_address !== addr) begin
        n_err++;
        $display("FAIL l2_address cyc%0d: got %h required %h", c + 1, l2_address, addr);
      end
      if (is_wr) begin
        n_cmp++;
        if (l2_wdata !== wd) begin
          n_err++;
          $display("FAIL l2_wdata cyc%0d: got %h required %h", c + 1, l2_wdata, wd);
        end
      end
      n_cmp++;
      if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin
        n_err++;
        $display("FAIL early_resp cyc%0d: got %b required 00", c + 1, {i_pmem_resp, d_pmem_resp});
      end
      if (scramble) begin
        i_pmem_address = 16'($urandom);
        d_pmem_address = 16'($urandom);
        d_pmem_wdata   = rand_line();
      end
      if (c == delay) begin
        l2_resp  = 1'b1;
        l2_rdata = rline;
      end
      step();
    end
    l2_resp  = 1'b0;
    l2_rdata = rand_line();
    if (!is_wr) exp_line = rline;
    n_cmp++;
    if ({i_pmem_resp, d_pmem_resp} !== {~owner, owner}) begin
      n_err++;
      $display("FAIL resp_owner: got %b required %b", {i_pmem_resp, d_pmem_resp}, {~owner, owner});
    end
    n_cmp++;
    if ({l2_read, l2_write} !== 2'b00) begin
      n_err++;
      $display("FAIL l2_req_in_resp: got %b required 00", {l2_read, l2_write});
    end
    n_cmp++;
    if (i_pmem_rdata !== exp_line || d_pmem_rdata !== exp_line) begin
      n_err++;
      $display("FAIL rdata: got i=%h d=%h required %h", i_pmem_rdata, d_pmem_rdata, exp_line);
    end
    if (owner) begin
      d_pmem_read  = 1'b0;
      d_pmem_write = 1'b0;
    end else begin
      i_pmem_read = 1'b0;
    end
  endtask

  task automatic check_all_zero(input string tag);
    n_cmp++;
    if ({l2_read, l2_write, i_pmem_resp, d_pmem_resp} !== 4'b0000 || l2_address !== 16'h0000 ||
        l2_wdata !== 128'd0 || i_pmem_rdata !== 128'd0 || d_pmem_rdata !== 128'd0) begin
      n_err++;
      $display("FAIL %s: got ctl=%b addr=%h wdata=%h rdata=%h required all zero", tag,
               {l2_read, l2_write, i_pmem_resp, d_pmem_resp}, l2_address, l2_wdata, i_pmem_rdata);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    i_pmem_read = 1'b0; i_pmem_address = 16'h0000;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0;
    d_pmem_address = 16'h0000; d_pmem_wdata = 128'd0;
    l2_rdata = 128'd0; l2_resp = 1'b0;
    model_last_d = 1'b1;
    exp_line = 128'd0;
    step(); step();
    check_all_zero("reset_state");
    @(negedge clk);
    reset_n = 1'b1;
    step(); step();
    check_all_zero("idle_after_reset");
  endtask

  task automatic test_icache_fill();
    bit owner;
    i_pmem_read = 1'b1;
    i_pmem_address = 16'h1230;
    run_txn(2, 128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, 1'b0, owner);
    n_cmp++;
    if (owner !== 1'b0) begin
      n_err++;
      $display("FAIL icache_fill_owner: got %0d required 0", owner);
    end
    step();
  endtask

  task automatic test_dcache_writeback();
    bit owner;
    d_pmem_write = 1'b1;
    d_pmem_address = 16'h8000;
    d_pmem_wdata = {16{8'hA5}};
    run_txn(1, rand_line(), 1'b0, owner);
    n_cmp++;
    if (owner !== 1'b1) begin
      n_err++;
      $display("FAIL writeback_owner: got %0d required 1", owner);
    end
    step();
  endtask

  // Both requesters re-request immediately; last winner was the dcache
  task automatic test_tie_round_robin();
    bit owner;
    i_pmem_read = 1'b1; i_pmem_address = 16'h2000;
    d_pmem_read = 1'b1; d_pmem_address = 16'h3000;
    for (int j = 0; j < 4; j++) begin
      run_txn(int'($urandom_range(0, 3)), rand_line(), 1'b0, owner);
      n_cmp++;
      if (owner !== j[0]) begin
        n_err++;
        $display("FAIL tie_order txn%0d: got %0d required %0d", j, owner, j[0]);
      end
      step();
      if (j < 3) begin
        if (owner) d_pmem_read = 1'b1;
        else       i_pmem_read = 1'b1;
      end
    end
    i_pmem_read = 1'b0;
    d_pmem_read = 1'b0;
    step();
  endtask

  task automatic test_input_change();
    bit owner;
    d_pmem_read = 1'b1;
    d_pmem_address = 16'h4440;
    run_txn(3, rand_line(), 1'b1, owner);
    step();
  endtask

  task automatic test_reset_mid_serve();
    bit owner;
    i_pmem_read = 1'b1;
    i_pmem_address = 16'h5550;
    step();
    n_cmp++;
    if (l2_read !== 1'b1) begin
      n_err++;
      $display("FAIL pre_reset_read: got %b required 1", l2_read);
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    i_pmem_read = 1'b0;
    model_last_d = 1'b1;
    exp_line = 128'd0;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    i_pmem_read = 1'b1; i_pmem_address = 16'h6660;
    d_pmem_read = 1'b1; d_pmem_address = 16'h7770;
    run_txn(1, rand_line(), 1'b0, owner);
    n_cmp++;
    if (owner !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset_tie: got %0d required 0", owner);
    end
    step();
    run_txn(0, rand_line(), 1'b0, owner);
    step();
  endtask

  task automatic test_zero_wait();
    bit owner;
    i_pmem_read = 1'b1; i_pmem_address = 16'h0A00;
    d_pmem_write = 1'b1; d_pmem_address = 16'h0B00; d_pmem_wdata = rand_line();
    run_txn(0, rand_line(), 1'b0, owner);
    step();
    run_txn(0, rand_line(), 1'b0, owner);
    step();
  endtask

  task automatic test_random();
    bit owner;
    int kind;
    for (int n = 0; n < 60; n++) begin
      if (!i_pmem_read) begin
        i_pmem_read = 1'($urandom_range(0, 1));
        i_pmem_address = 16'($urandom);
      end
      if (!(d_pmem_read || d_pmem_write)) begin
        kind = int'($urandom_range(0, 3));
        d_pmem_read  = (kind == 1 || kind == 3);
        d_pmem_write = (kind == 2 || kind == 3);
        d_pmem_address = 16'($urandom);
        d_pmem_wdata = rand_line();
      end
      if (i_pmem_read || d_pmem_read || d_pmem_write) begin
        run_txn(int'($urandom_range(0, 3)), rand_line(), 1'($urandom_range(0, 1)), owner);
        step();
      end else begin
        step();
        n_cmp++;
        if ({l2_read, l2_write, i_pmem_resp, d_pmem_resp} !== 4'b0000) begin
          n_err++;
          $display("FAIL idle_quiet: got %b required 0000", {l2_read, l2_write, i_pmem_resp, d_pmem_resp});
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_icache_fill();
    test_dcache_writeback();
    test_tie_round_robin();
    test_input_change();
    test_reset_mid_serve();
    test_zero_wait();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/l1_mem_arbiter.md
# l1_mem_arbiter

Two-port arbiter directly downstream of the L1 instruction cache and L1 data cache. It accepts line-fill requests from the icache (read-only) and line fill/writeback requests from the dcache, and serializes them onto the single L2/physical-memory port. One transaction is outstanding at a time. Ties are broken round-robin, and the line returned by L2 is registered before it is handed back to the requester.

## Interface
- No parameters. Widths are fixed by `lc3b_types`: `lc3b_word` = 16 bits, `pmem_L1_bus` = 128 bits (one 8-word line).
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `i_pmem_read` in 1: icache line-fill request, held high until `i_pmem_resp`.
- `i_pmem_address` in 16: icache line address, stable while `i_pmem_read` is high.
- `i_pmem_rdata` out 128: fill line to the icache, valid while `i_pmem_resp` is high.
- `i_pmem_resp` out 1: one-cycle completion pulse to the icache.
- `d_pmem_read` in 1: dcache line-fill request.
- `d_pmem_write` in 1: dcache writeback request. `d_pmem_read` and `d_pmem_write` are never both high; if they are, the arbiter treats the request as a write.
- `d_pmem_address` in 16: dcache line address.
- `d_pmem_wdata` in 128: writeback line.
- `d_pmem_rdata` out 128: fill line to the dcache.
- `d_pmem_resp` out 1: one-cycle completion pulse to the dcache.
- `l2_read` out 1: read request to L2, held until `l2_resp`.
- `l2_write` out 1: write request to L2, held until `l2_resp`.
- `l2_address` out 16: latched request address.
- `l2_wdata` out 128: latched write line.
- `l2_rdata` in 128: read line from L2, valid while `l2_resp` is high.
- `l2_resp` in 1: L2 completion, one cycle.

## Operation
- FSM states: IDLE, SERVE, RESP.
- IDLE
  - If no request is pending, remain in IDLE.
  - If exactly one requester is pending, grant it.
  - If both are pending, grant the requester that was NOT granted last (`last_grant`).
  - On a grant: latch the owner (I or D), the operation (read/write), the address and the wdata (D write only). Set `last_grant` to the owner. Go to SERVE.
- SERVE
  - `l2_read` or `l2_write` is driven high from the latched operation. `l2_address` and `l2_wdata` come from the latch registers.
  - New requests are ignored in this state.
  - On `l2_resp`: capture `l2_rdata` into the line register (for reads only) and go to RESP.
- RESP
  - `l2_read` and `l2_write` are 0.
  - The owner's `*_pmem_resp` is 1 for exactly this cycle. The owner's `*_pmem_rdata` is driven from the line register. Go to IDLE.
- `i_pmem_rdata` and `d_pmem_rdata` both continuously drive the line register; only the `*_pmem_resp` signals are qualified by owner.
- `last_grant` resets to D, so the first tie after reset goes to the icache.
- Requester contract: a requester drops its request in the cycle after its resp, so IDLE does not re-grant a completed request.
- Reset (asynchronous, any state):
  - Go to IDLE, `last_grant` = D.
  - Latch registers and line register = 0.
  - All outputs 0.
  - Any in-flight L2 transaction is abandoned; L2 is reset on the same `reset_n`.

## Timing
- Request is seen high in IDLE at cycle 0 → `l2_read`/`l2_write` high from cycle 1. They stay high through the cycle in which `l2_resp` is 1 (cycle k ≥ 1).
- `*_pmem_resp` is high in cycle k+1.
- Minimum latency from request to resp: 2 cycles (`l2_resp` in cycle 1).
- Back-to-back: the next grant is sampled in the IDLE cycle k+2, so the next L2 request starts at k+3.
- The L2 request outputs are registered and never glitch on requester input changes during SERVE.
- Address and wdata are sampled only at grant; later changes to requester inputs do not affect the transaction in progress.

## Test plan
- Single icache fill:
  - Stimulus: `i_pmem_read`=1, `i_pmem_address`=0x1230; L2 returns 0x0123...CDEF after 3 cycles.
  - Required: `l2_read`=1 with `l2_address`=0x1230 from cycle 1; `i_pmem_resp`=1 for exactly one cycle, with that line, one cycle after `l2_resp`; `d_pmem_resp` stays 0.
- Dcache writeback:
  - Stimulus: `d_pmem_write`=1, address 0x8000, wdata all-0xA5.
  - Required: `l2_write`=1 carrying that address and data; `d_pmem_resp` pulses once; `l2_read` never goes high.
- Simultaneous requests from reset:
  - Stimulus: I and D both request, and both re-request immediately after each completion.
  - Required: grant order is I, D, I, D; no resp pulse goes to the non-owner.
- Requester input change mid-transaction:
  - Stimulus: change `d_pmem_address` while in SERVE.
  - Required: `l2_address` keeps the value latched at grant.
- Reset mid-SERVE:
  - Stimulus: drop `reset_n` while `l2_read`=1.
  - Required: all outputs 0 immediately (asynchronously); after release, the first tie is granted to I.
- Zero-wait L2:
  - Stimulus: `l2_resp` asserted in the first SERVE cycle.
  - Required: resp is delivered 2 cycles after the request; a pending second request is granted in the following IDLE cycle.
